alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Parametrised, registered execution unit for the MIPS5 EX stage. It supersedes the purely combinational ALU and adds a valid/ready handshake, SLTU and SRA, and a multi-cycle iterative MULT/MULTU/DIV/DIVU datapath with architectural HI/LO registers. Single-cycle ops sustain one result per clock. Multiply and divide stall the issuing pipeline via in_ready.

Parameters:
WIDTH, 32, datapath width in bits (any power of two >= 8); localparam SHAMT_W = $clog2(WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation present on data1/data2/shamt/alu_ctrl
in_ready  output  1  unit can accept an operation this cycle
data1  input  WIDTH  operand A (rs); dividend/multiplicand
data2  input  WIDTH  operand B (rt); divisor/multiplier
shamt  input  SHAMT_W  shift amount
alu_ctrl  input  5  operation select
out_valid  output  1  one-cycle pulse; alu_res/zero valid
alu_res  output  WIDTH  registered result
zero  output  1  (alu_res == 0)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Encoding, legacy codes kept: SLL 00000, ADD 00001, SUB 00010, AND 00100, OR 00101, XOR 00110, LUI 00111, SLT 01010, SRL 01111.
- New codes: SLTU 10000, SRA 10001, MULT 10010, MULTU 10011, DIV 10100, DIVU 10101, MFHI 10110, MFLO 10111, MTHI 11000, MTLO 11001.
- Any other code: accepted, 1-cycle, alu_res = 0.
- Accept = in_valid && in_ready. in_ready = (state == IDLE).
- FSM states: IDLE, CALC, FIN.
- Single-cycle ops (all except MULT/MULTU/DIV/DIVU) stay in IDLE. alu_res is registered at the accept edge, and out_valid is high for the following cycle. Back-to-back issue gives one result per cycle.
- ADD/SUB: modulo 2^WIDTH, no overflow trap.
- SLT: signed compare. SLTU: unsigned compare. Both return 1 or 0.
- LUI: alu_res = {data2[WIDTH/2-1:0], WIDTH/2 zeros}.
- SLL/SRL: logical shift of data2 by shamt. SRA: arithmetic shift of data2 by shamt.
- MFHI/MFLO: alu_res = hi/lo.
- MTHI/MTLO: hi/lo <= data1 and alu_res = data1.
- MULT/MULTU/DIV/DIVU sequence:
  - At the accept edge: latch operands (absolute values for signed ops), record the result signs, load counter = WIDTH, go to CALC.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle for WIDTH cycles, then go to FIN.
  - FIN: apply sign correction, write hi/lo, set alu_res = final lo, pulse out_valid, return to IDLE.
  - in_ready is low for exactly WIDTH+1 cycles. out_valid rises WIDTH+1 cycles after accept, in the same cycle in_ready returns high.
- Multiply result: {hi, lo} = full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
- Divide result: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (DIV or DIVU): lo = all ones, hi = data1. Normal latency.
- DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1), hi = 0.
- hi/lo change only at the FIN edge or on MTHI/MTLO. While busy, an MFHI/MFLO held on in_valid is accepted in the out_valid cycle and returns the new value.
- Operand inputs are ignored while not accepting.
- Reset values: state IDLE, out_valid 0, alu_res 0, zero 1, hi 0, lo 0, counter 0.
- in_ready is 0 while rst is high and 1 in the first cycle after rst drops.
- Reset mid-operation: the op is aborted, no out_valid, hi/lo cleared.
- in_valid asserted during rst is ignored.

Test Plan:
- ADD 0x7FFFFFFF+0x1 accepted at cycle N -> out_valid at N+1, alu_res 0x80000000, zero 0. SUB 5-5 issued at N+1 -> out_valid at N+2, alu_res 0, zero 1.
- MULT -3*7 -> in_ready low 33 cycles; out_valid 33 cycles after accept; hi 0xFFFFFFFF, lo 0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001.
- DIV -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 7/0 -> lo 0xFFFFFFFF, hi 0x7. DIV 0x80000000/0xFFFFFFFF -> lo 0x80000000, hi 0.
- MFLO held on in_valid throughout a MULTU 6*7 -> accepted in the out_valid cycle; alu_res 42 one cycle later.
- rst pulsed 10 cycles into a MULTU -> no out_valid; hi = lo = 0; in_ready 1 in the first cycle after rst falls.
- SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same -> 0. LUI data2 0x1234 -> 0x12340000. Undefined code 11111 -> alu_res 0, zero 1.

Source files
------------

// File: rtl/alu_muldiv.sv
// Registered MIPS5 EX-stage ALU with valid/ready handshake, HI/LO registers and an iterative
// shift-add multiplier / restoring divider that holds in_ready low while it runs.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [4:0]         alu_ctrl,
    output logic               out_valid,
    output logic [WIDTH-1:0]   alu_res,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    localparam int unsigned CNT_W = SHAMT_W + 1;

    localparam logic [4:0] OpSll   = 5'b00000;
    localparam logic [4:0] OpAdd   = 5'b00001;
    localparam logic [4:0] OpSub   = 5'b00010;
    localparam logic [4:0] OpAnd   = 5'b00100;
    localparam logic [4:0] OpOr    = 5'b00101;
    localparam logic [4:0] OpXor   = 5'b00110;
    localparam logic [4:0] OpLui   = 5'b00111;
    localparam logic [4:0] OpSlt   = 5'b01010;
    localparam logic [4:0] OpSrl   = 5'b01111;
    localparam logic [4:0] OpSltu  = 5'b10000;
    localparam logic [4:0] OpSra   = 5'b10001;
    localparam logic [4:0] OpMult  = 5'b10010;
    localparam logic [4:0] OpMultu = 5'b10011;
    localparam logic [4:0] OpDiv   = 5'b10100;
    localparam logic [4:0] OpDivu  = 5'b10101;
    localparam logic [4:0] OpMfhi  = 5'b10110;
    localparam logic [4:0] OpMflo  = 5'b10111;
    localparam logic [4:0] OpMthi  = 5'b11000;
    localparam logic [4:0] OpMtlo  = 5'b11001;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             out_valid_q, out_valid_d;

    logic               accept, is_muldiv, is_signed, div_op, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   abs_a, abs_b, simple_res, div_q_fix, div_r_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign in_ready  = (state_q == StIdle) && !rst;
    assign accept    = in_valid && in_ready;
    assign is_muldiv = (alu_ctrl == OpMult) || (alu_ctrl == OpMultu) ||
                       (alu_ctrl == OpDiv) || (alu_ctrl == OpDivu);
    assign is_signed = (alu_ctrl == OpMult) || (alu_ctrl == OpDiv);
    assign div_op    = (alu_ctrl == OpDiv) || (alu_ctrl == OpDivu);
    assign a_neg     = is_signed && data1[WIDTH-1];
    assign b_neg     = is_signed && data2[WIDTH-1];
    assign b_zero    = (data2 == '0);
    assign abs_a     = a_neg ? -data1 : data1;
    assign abs_b     = b_neg ? -data2 : data2;

    // acc holds the product high half / partial remainder; quo holds multiplier / quotient bits.
    assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign prod      = {acc_q, quo_q};
    assign prod_fix  = neg_lo_q ? -prod : prod;
    assign div_q_fix = neg_lo_q ? -quo_q : quo_q;
    assign div_r_fix = neg_hi_q ? -acc_q : acc_q;

    always_comb begin
        simple_res = '0;
        case (alu_ctrl)
            OpSll:          simple_res = data2 << shamt;
            OpAdd:          simple_res = data1 + data2;
            OpSub:          simple_res = data1 - data2;
            OpAnd:          simple_res = data1 & data2;
            OpOr:           simple_res = data1 | data2;
            OpXor:          simple_res = data1 ^ data2;
            OpLui:          simple_res = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OpSlt:          simple_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
            OpSrl:          simple_res = data2 >> shamt;
            OpSltu:         simple_res = {{(WIDTH-1){1'b0}}, data1 < data2};
            OpSra:          simple_res = $unsigned($signed(data2) >>> shamt);
            OpMfhi:         simple_res = hi_q;
            OpMflo:         simple_res = lo_q;
            OpMthi, OpMtlo: simple_res = data1;
            default:        simple_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        quo_d       = quo_q;
        opb_d       = opb_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && is_muldiv) begin
                    is_div_d = div_op;
                    // A zero divisor yields an all-ones quotient that must not be negated.
                    neg_lo_d = (a_neg ^ b_neg) && !(div_op && b_zero);
                    neg_hi_d = a_neg;
                    acc_d    = '0;
                    quo_d    = div_op ? abs_a : abs_b;
                    opb_d    = div_op ? abs_b : abs_a;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = StCalc;
                end else if (accept) begin
                    res_d       = simple_res;
                    out_valid_d = 1'b1;
                    if (alu_ctrl == OpMthi) hi_d = data1;
                    if (alu_ctrl == OpMtlo) lo_d = data1;
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], !div_diff[WIDTH]};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = StFin;
            end
            StFin: begin
                hi_d        = is_div_q ? div_r_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_d        = is_div_q ? div_q_fix : prod_fix[WIDTH-1:0];
                res_d       = lo_d;
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            quo_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            opb_q       <= opb_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_res   = res_q;
    assign zero      = (res_q == '0);
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: expected results queued at issue, popped at out_valid.
module tb_alu_muldiv;
    localparam logic [4:0] OpSll = 5'b00000, OpAdd = 5'b00001, OpSub = 5'b00010;
    localparam logic [4:0] OpAnd = 5'b00100, OpOr = 5'b00101, OpXor = 5'b00110;
    localparam logic [4:0] OpLui = 5'b00111, OpSlt = 5'b01010, OpSrl = 5'b01111;
    localparam logic [4:0] OpSltu = 5'b10000, OpSra = 5'b10001, OpMult = 5'b10010;
    localparam logic [4:0] OpMultu = 5'b10011, OpDiv = 5'b10100, OpDivu = 5'b10101;
    localparam logic [4:0] OpMfhi = 5'b10110, OpMflo = 5'b10111, OpMthi = 5'b11000;
    localparam logic [4:0] OpMtlo = 5'b11001, OpBad = 5'b11111;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, zero;
    logic [31:0] data1, data2, alu_res, hi, lo;
    logic [4:0]  shamt, alu_ctrl;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
    } svec_t;
    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } mvec_t;

    exp_t sb[$];

    alu_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data1    (data1),
        .data2    (data2),
        .shamt    (shamt),
        .alu_ctrl (alu_ctrl),
        .out_valid(out_valid),
        .alu_res  (alu_res),
        .zero     (zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, checks=%0d", checks);
        $fatal(1);
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alu_ctrl = op;
        data1    = a;
        data2    = b;
        shamt    = sh;
        in_valid = 1'b1;
    endtask

    // Called at the negedge after the accept edge; lat counts rising edges from the accept edge
    // to the edge that raised out_valid, busy counts sampled cycles with in_ready low.
    task automatic wait_out(input int budget, output int lat, output int busy, output bit seen);
        lat  = 0;
        busy = 0;
        seen = 1'b0;
        while (!seen && lat < budget) begin
            if (in_ready !== 1'b1) busy++;
            if (out_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(OpAdd, 32'd1, 32'd1, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || alu_res !== 32'h0 || zero !== 1'b1 ||
            hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b res=%h zero=%b hi=%h lo=%h, want 0 0 0 1 0 0",
                     in_ready, out_valid, alu_res, zero, hi, lo);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_valid: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        drive(OpAdd, 32'h7FFFFFFF, 32'h1, 5'd0);
        sb.push_back(exp_t'{32'h80000000, 32'h0, 32'h0});
        @(negedge clk);
        drive(OpSub, 32'd5, 32'd5, 5'd0);
        sb.push_back(exp_t'{32'h0, 32'h0, 32'h0});
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_res !== e.res || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: ov=%b res=%h zero=%b, want 1 %h 0", out_valid, alu_res, zero,
                     e.res);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_res !== e.res || zero !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sub: ov=%b res=%h zero=%b, want 1 %h 1", out_valid, alu_res, zero,
                     e.res);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_single_ops();
        svec_t tbl[$];
        svec_t v;
        exp_t  e;
        tbl.push_back(svec_t'{OpSra, 32'h0, 32'h80000000, 5'd4, 32'hF8000000});
        tbl.push_back(svec_t'{OpSrl, 32'h0, 32'h80000000, 5'd4, 32'h08000000});
        tbl.push_back(svec_t'{OpSll, 32'h0, 32'h00000003, 5'd31, 32'h80000000});
        tbl.push_back(svec_t'{OpSltu, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1});
        tbl.push_back(svec_t'{OpSlt, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0});
        tbl.push_back(svec_t'{OpLui, 32'h0, 32'h00001234, 5'd0, 32'h12340000});
        tbl.push_back(svec_t'{OpBad, 32'h5, 32'h6, 5'd3, 32'h0});
        tbl.push_back(svec_t'{OpAnd, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000});
        tbl.push_back(svec_t'{OpOr, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0});
        tbl.push_back(svec_t'{OpXor, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0});
        tbl.push_back(svec_t'{OpSub, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE});
        tbl.push_back(svec_t'{OpAdd, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0});
        tbl.push_back(svec_t'{OpMthi, 32'hDEADBEEF, 32'h0, 5'd0, 32'hDEADBEEF});
        tbl.push_back(svec_t'{OpMtlo, 32'h12345678, 32'h0, 5'd0, 32'h12345678});
        tbl.push_back(svec_t'{OpMfhi, 32'h0, 32'h0, 5'd0, 32'hDEADBEEF});
        tbl.push_back(svec_t'{OpMflo, 32'h0, 32'h0, 5'd0, 32'h12345678});
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            drive(v.op, v.a, v.b, v.sh);
            sb.push_back(exp_t'{v.res, 32'h0, 32'h0});
            @(negedge clk);
            in_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || alu_res !== e.res || zero !== (e.res == 32'h0)) begin
                errors++;
                $display("FAIL single[%0d] op=%b: ov=%b res=%h zero=%b, want 1 %h %b", i, v.op,
                         out_valid, alu_res, zero, e.res, e.res == 32'h0);
            end
        end
    endtask

    task automatic test_muldiv();
        mvec_t tbl[$];
        mvec_t v;
        exp_t  e;
        int    lat, busy;
        bit    seen;
        tbl.push_back(mvec_t'{OpMult, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB});
        tbl.push_back(mvec_t'{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1});
        tbl.push_back(mvec_t'{OpMult, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
        tbl.push_back(mvec_t'{OpMultu, 32'h12345678, 32'h100, 32'h12, 32'h34567800});
        tbl.push_back(mvec_t'{OpDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back(mvec_t'{OpDivu, 32'd7, 32'd0, 32'h7, 32'hFFFFFFFF});
        tbl.push_back(mvec_t'{OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
        tbl.push_back(mvec_t'{OpDiv, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD});
        tbl.push_back(mvec_t'{OpDivu, 32'd100, 32'd7, 32'd2, 32'd14});
        tbl.push_back(mvec_t'{OpDiv, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF});
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            drive(v.op, v.a, v.b, 5'd0);
            sb.push_back(exp_t'{v.lo, v.hi, v.lo});
            @(negedge clk);
            in_valid = 1'b0;
            wait_out(40, lat, busy, seen);
            checks++;
            if (!seen || lat != 33 || busy != 33) begin
                errors++;
                $display("FAIL muldiv_timing[%0d] op=%b: seen=%b lat=%0d busy=%0d, want 1 33 33",
                         i, v.op, seen, lat, busy);
            end
            e = sb.pop_front();
            checks++;
            if (alu_res !== e.res || zero !== (e.res == 32'h0) || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL muldiv[%0d] op=%b: res=%h zero=%b hi=%h lo=%h, want %h %b %h %h",
                         i, v.op, alu_res, zero, hi, lo, e.res, e.res == 32'h0, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_mflo_held();
        exp_t e;
        int   lat, busy;
        bit   seen;
        @(negedge clk);
        drive(OpMultu, 32'd6, 32'd7, 5'd0);
        sb.push_back(exp_t'{32'd42, 32'h0, 32'd42});
        @(negedge clk);
        drive(OpMflo, 32'h0, 32'h0, 5'd0);
        sb.push_back(exp_t'{32'd42, 32'h0, 32'd42});
        wait_out(40, lat, busy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || lat != 33 || alu_res !== e.res || hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL mflo_held_mul: seen=%b lat=%0d res=%h hi=%h lo=%h, want 1 33 %h %h %h",
                     seen, lat, alu_res, hi, lo, e.res, e.hi, e.lo);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_res !== e.res) begin
            errors++;
            $display("FAIL mflo_held_read: ov=%b res=%h, want 1 %h", out_valid, alu_res, e.res);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        @(negedge clk);
        drive(OpMultu, 32'd5, 32'd9, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_op: rdy=%b ov=%b hi=%h lo=%h, want 1 0 0 0",
                     in_ready, out_valid, hi, lo);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: out_valid pulses=%0d hi=%h lo=%h, want 0 0 0",
                     pulses, hi, lo);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        data1    = '0;
        data2    = '0;
        shamt    = '0;
        alu_ctrl = '0;
        test_reset();
        test_back_to_back();
        test_single_ops();
        test_muldiv();
        test_mflo_held();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
